// File: rtl/pcie_tx_framer_pkg.sv
// Shared PCIe framing definitions: 8b/10b K-code byte values and framer states.
package pcie_tx_framer_pkg;

    localparam logic [7:0] K_COM = 8'hBC;  // K28.5
    localparam logic [7:0] K_SKP = 8'h1C;  // K28.0
    localparam logic [7:0] K_STP = 8'hFB;  // K27.7
    localparam logic [7:0] K_SDP = 8'h5C;  // K28.2
    localparam logic [7:0] K_END = 8'hFD;  // K29.7
    localparam logic [7:0] K_EDB = 8'hFE;  // K30.7
    localparam logic [7:0] K_PAD = 8'hF7;  // K23.7

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PKT,
        ST_TAIL,
        ST_SKP
    } framer_state_e;

endpackage

// File: rtl/pcie_tx_framer_skp_timer.sv
// SKP interval timer: free-running 12-bit counter plus a non-stacking pending flag.
module pcie_skp_timer #(
    parameter int unsigned SKP_INTERVAL = 1180
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic pending,
    output logic pending_next
);

    logic [11:0] cnt;
    logic        wrap;

    assign wrap = (cnt == 12'(SKP_INTERVAL - 1));

    // A wrap coinciding with the start of an owed SKP is absorbed by it.
    always_comb begin
        pending_next = pending;
        if (start)
            pending_next = 1'b0;
        else if (wrap)
            pending_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            cnt     <= wrap ? '0 : cnt + 12'd1;
            pending <= pending_next;
        end
    end

endmodule

// File: rtl/pcie_tx_framer.sv
// PCIe transmit framer: wraps TLP/DLLP beats with STP/SDP and END/EDB/PAD symbols.
// SKP ordered-set insertion is built only when PCIE_FRAMER_SKP_EN is defined.
module pcie_tx_framer
    import pcie_tx_framer_pkg::*;
#(
    parameter int unsigned LANES        = 4,
    parameter int unsigned SKP_INTERVAL = 1180
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_sop,
    input  logic                 in_eop,
    input  logic                 in_kind,
    input  logic [2:0]           in_nbytes,
    input  logic                 in_bad,
    output logic [8*LANES-1:0]   tx_data,
    output logic [LANES-1:0]     tx_k,
    output logic                 skp_pending
);

    framer_state_e        state, next_state;
    logic [7:0]           carry, carry_next;
    logic                 tail_bad, tail_bad_next;
    logic                 tail_carry, tail_carry_next;
    logic [1:0]           skp_phase, phase_next;
    logic [8*LANES-1:0]   data_d;
    logic [LANES-1:0]     k_d;
    logic                 accept;
    logic                 pend_next;
    logic                 in_ready_d;
    int unsigned          nb;

`ifdef PCIE_FRAMER_SKP_EN
    logic skp_start;
    assign skp_start = (state != ST_SKP) && (next_state == ST_SKP);

    pcie_skp_timer #(.SKP_INTERVAL(SKP_INTERVAL)) u_skp_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (skp_start),
        .pending      (skp_pending),
        .pending_next (pend_next)
    );
`else
    assign skp_pending = 1'b0;
    assign pend_next   = 1'b0;
`endif

    always_comb begin
        next_state      = state;
        carry_next      = carry;
        tail_bad_next   = tail_bad;
        tail_carry_next = tail_carry;
        phase_next      = skp_phase;
        data_d          = '0;
        k_d             = '0;
        accept          = in_valid && in_ready;
        nb              = {29'd0, in_nbytes};
        case (state)
            ST_IDLE: begin
                if (skp_pending) begin
                    next_state = ST_SKP;
                end else if (accept && in_sop) begin
                    data_d[7:0] = in_kind ? K_SDP : K_STP;
                    k_d[0]      = 1'b1;
                    for (int unsigned i = 1; i < LANES; i++)
                        data_d[8*i +: 8] = in_data[8*(i-1) +: 8];
                    carry_next = in_data[8*(LANES-1) +: 8];
                    next_state = ST_PKT;
                end
            end
            ST_PKT: begin
                // in_sop is deliberately ignored here; every accepted beat is payload.
                if (accept) begin
                    data_d[7:0] = carry;
                    for (int unsigned i = 1; i < LANES; i++)
                        data_d[8*i +: 8] = in_data[8*(i-1) +: 8];
                    if (in_eop && (nb + 2 <= LANES)) begin
                        for (int unsigned i = 1; i < LANES; i++) begin
                            if (i == nb + 1) begin
                                data_d[8*i +: 8] = in_bad ? K_EDB : K_END;
                                k_d[i]           = 1'b1;
                            end else if (i > nb + 1) begin
                                data_d[8*i +: 8] = K_PAD;
                                k_d[i]           = 1'b1;
                            end
                        end
                        next_state = skp_pending ? ST_SKP : ST_IDLE;
                    end else begin
                        carry_next = in_data[8*(LANES-1) +: 8];
                        if (in_eop) begin
                            tail_bad_next   = in_bad;
                            tail_carry_next = (nb == LANES);
                            next_state      = ST_TAIL;
                        end
                    end
                end
            end
            ST_TAIL: begin
                k_d = '1;
                for (int unsigned i = 0; i < LANES; i++)
                    data_d[8*i +: 8] = K_PAD;
                if (tail_carry) begin
                    data_d[7:0]  = carry;
                    k_d[0]       = 1'b0;
                    data_d[15:8] = tail_bad ? K_EDB : K_END;
                end else begin
                    data_d[7:0] = tail_bad ? K_EDB : K_END;
                end
                next_state = skp_pending ? ST_SKP : ST_IDLE;
            end
            ST_SKP: begin
                k_d = '1;
                for (int unsigned i = 0; i < LANES; i++)
                    data_d[8*i +: 8] = (skp_phase == 2'd0) ? K_COM : K_SKP;
                phase_next = skp_phase + 2'd1;
                if (skp_phase == 2'd3)
                    next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        // in_ready is registered, so it is derived from the state being entered.
        in_ready_d = (next_state == ST_PKT) || ((next_state == ST_IDLE) && !pend_next);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            carry      <= '0;
            tail_bad   <= 1'b0;
            tail_carry <= 1'b0;
            skp_phase  <= '0;
            tx_data    <= '0;
            tx_k       <= '0;
            in_ready   <= 1'b0;
        end else begin
            state      <= next_state;
            carry      <= carry_next;
            tail_bad   <= tail_bad_next;
            tail_carry <= tail_carry_next;
            skp_phase  <= phase_next;
            tx_data    <= data_d;
            tx_k       <= k_d;
            in_ready   <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_pcie_tx_framer.sv
// Directed self-checking bench for pcie_tx_framer (4-lane, 2-lane and short-SKP-interval instances).
module tb_pcie_tx_framer;

    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] ENDK = 8'hFD;
    localparam logic [7:0] EDB = 8'hFE;
    localparam logic [7:0] PAD = 8'hF7;
    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] d;
    logic        sop, eop, kind, bad;
    logic [2:0]  nb;
    logic        v4, v2, v16;

    logic        r4, r2, r16;
    logic [31:0] td4, td16;
    logic [15:0] td2;
    logic [3:0]  k4, k16;
    logic [1:0]  k2;
    logic        p4, p2, p16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pcie_tx_framer #(.LANES(4), .SKP_INTERVAL(4095)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_data(d),
        .in_sop(sop), .in_eop(eop), .in_kind(kind), .in_nbytes(nb), .in_bad(bad),
        .tx_data(td4), .tx_k(k4), .skp_pending(p4));

    pcie_tx_framer #(.LANES(2), .SKP_INTERVAL(4095)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .in_data(d[15:0]),
        .in_sop(sop), .in_eop(eop), .in_kind(kind), .in_nbytes(nb), .in_bad(bad),
        .tx_data(td2), .tx_k(k2), .skp_pending(p2));

    pcie_tx_framer #(.LANES(4), .SKP_INTERVAL(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .in_data(d),
        .in_sop(sop), .in_eop(eop), .in_kind(kind), .in_nbytes(nb), .in_bad(bad),
        .tx_data(td16), .tx_k(k16), .skp_pending(p16));

    function automatic logic [31:0] l4(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] e);
        return {e, c, b, a};
    endfunction

    function automatic logic [7:0] bb(input int i, input int j);
        return 8'(i * 4 + j);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; d = '0; sop = 0; eop = 0; kind = 0; bad = 0; nb = 3'd0;
        v4 = 0; v2 = 0; v16 = 0;
        repeat (3) tick();
        chk("reset_u4",  {r4, p4, k4, td4},   40'h0);
        chk("reset_u2",  {r2, p2, k2, td2},   40'h0);
        chk("reset_u16", {r16, p16, k16, td16}, 40'h0);

        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", {r4, r2, r16}, 40'h7);

`ifdef PCIE_FRAMER_SKP_EN
        // long TLP on u16; the 16-cycle SKP interval expires mid-packet
        v16 = 1; sop = 1; kind = 0; d = l4(bb(1,0), bb(1,1), bb(1,2), bb(1,3));
        tick();
        chk("skp_sop", {k16, td16}, {4'b0001, l4(STP, bb(1,0), bb(1,1), bb(1,2))});
        sop = 0;
        for (int i = 2; i <= 16; i++) begin
            d = l4(bb(i,0), bb(i,1), bb(i,2), bb(i,3));
            tick();
            chk("skp_mid", {k16, td16}, {4'b0000, l4(bb(i-1,3), bb(i,0), bb(i,1), bb(i,2))});
            if (i == 14) chk("skp_pend_pre", {39'd0, p16}, 40'd0);
            if (i == 15) chk("skp_pend_set", {39'd0, p16}, 40'd1);
            if (i == 16) chk("skp_ready_pkt", {39'd0, r16}, 40'd1);
        end
        eop = 1; nb = 3'd4; d = l4(bb(17,0), bb(17,1), bb(17,2), bb(17,3));
        tick();
        chk("skp_eop", {k16, td16}, {4'b0000, l4(bb(16,3), bb(17,0), bb(17,1), bb(17,2))});
        chk("skp_eop_flags", {r16, p16}, 40'b01);
        v16 = 0; eop = 0;
        tick();
        chk("skp_tail", {k16, td16}, {4'b1110, l4(bb(17,3), ENDK, PAD, PAD)});
        tick();
        chk("skp_com", {p16, k16, td16}, {1'b0, 4'b1111, l4(COM, COM, COM, COM)});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("skp_skp", {k16, td16}, {4'b1111, l4(SKP, SKP, SKP, SKP)});
        end
        tick();
        chk("skp_idle", {r16, k16, td16}, {1'b1, 4'b0000, 32'h0});
`endif

        // 8-byte TLP, eop with all lanes valid
        v4 = 1; sop = 1; kind = 0; d = l4(8'h01, 8'h02, 8'h03, 8'h04);
        tick();
        chk("tlp8_b1", {k4, td4}, {4'b0001, l4(STP, 8'h01, 8'h02, 8'h03)});
        sop = 0; eop = 1; nb = 3'd4; d = l4(8'h05, 8'h06, 8'h07, 8'h08);
        tick();
        chk("tlp8_b2", {r4, k4, td4}, {1'b0, 4'b0000, l4(8'h04, 8'h05, 8'h06, 8'h07)});
        v4 = 0; eop = 0;
        tick();
        chk("tlp8_tail", {k4, td4}, {4'b1110, l4(8'h08, ENDK, PAD, PAD)});
        tick();
        chk("tlp8_idle", {r4, k4, td4}, {1'b1, 4'b0000, 32'h0});

        // 6-byte DLLP with a bubble, eop n=2
        v4 = 1; sop = 1; kind = 1; d = l4(8'h10, 8'h11, 8'h12, 8'h13);
        tick();
        chk("dllp_b1", {k4, td4}, {4'b0001, l4(SDP, 8'h10, 8'h11, 8'h12)});
        v4 = 0; sop = 0; kind = 0;
        tick();
        chk("dllp_bubble", {r4, k4, td4}, {1'b1, 4'b0000, 32'h0});
        v4 = 1; eop = 1; nb = 3'd2; d = l4(8'h14, 8'h15, 8'hEE, 8'hEE);
        tick();
        chk("dllp_eop", {r4, k4, td4}, {1'b1, 4'b1000, l4(8'h13, 8'h14, 8'h15, ENDK)});
        v4 = 0; eop = 0;
        tick();
        chk("dllp_idle", {k4, td4}, {4'b0000, 32'h0});

        // nullified TLP, stray sop mid-packet ignored, eop n=1
        v4 = 1; sop = 1; d = l4(8'h20, 8'h21, 8'h22, 8'h23);
        tick();
        chk("bad_b1", {k4, td4}, {4'b0001, l4(STP, 8'h20, 8'h21, 8'h22)});
        d = l4(8'h24, 8'h25, 8'h26, 8'h27);
        tick();
        chk("bad_stray_sop", {k4, td4}, {4'b0000, l4(8'h23, 8'h24, 8'h25, 8'h26)});
        sop = 0; eop = 1; nb = 3'd1; bad = 1; d = l4(8'h28, 8'hEE, 8'hEE, 8'hEE);
        tick();
        chk("bad_eop", {k4, td4}, {4'b1100, l4(8'h27, 8'h28, EDB, PAD)});
        v4 = 0; eop = 0; bad = 0;
        tick();
        chk("bad_idle", {k4, td4}, {4'b0000, 32'h0});

        // 7-byte TLP, eop n=3 goes through TAIL
        v4 = 1; sop = 1; d = l4(8'h30, 8'h31, 8'h32, 8'h33);
        tick();
        chk("n3_b1", {k4, td4}, {4'b0001, l4(STP, 8'h30, 8'h31, 8'h32)});
        sop = 0; eop = 1; nb = 3'd3; d = l4(8'h34, 8'h35, 8'h36, 8'hEE);
        tick();
        chk("n3_eop", {k4, td4}, {4'b0000, l4(8'h33, 8'h34, 8'h35, 8'h36)});
        v4 = 0; eop = 0;
        tick();
        chk("n3_tail", {k4, td4}, {4'b1111, l4(ENDK, PAD, PAD, PAD)});
        tick();
        chk("n3_idle", {k4, td4}, {4'b0000, 32'h0});

        // 2-lane 7-byte TLP nullified, eop n=1
        v2 = 1; sop = 1; kind = 0; d = {16'h0, 8'h41, 8'h40};
        tick();
        chk("l2_b1", {k2, td2}, {2'b01, 8'h40, STP});
        sop = 0; d = {16'h0, 8'h43, 8'h42};
        tick();
        chk("l2_b2", {k2, td2}, {2'b00, 8'h42, 8'h41});
        d = {16'h0, 8'h45, 8'h44};
        tick();
        chk("l2_b3", {k2, td2}, {2'b00, 8'h44, 8'h43});
        eop = 1; nb = 3'd1; bad = 1; d = {16'h0, 8'hEE, 8'h46};
        tick();
        chk("l2_eop", {r2, k2, td2}, {1'b0, 2'b00, 8'h46, 8'h45});
        v2 = 0; eop = 0; bad = 0;
        tick();
        chk("l2_tail", {k2, td2}, {2'b11, PAD, EDB});
        tick();
        chk("l2_idle", {r2, k2, td2}, {1'b1, 2'b00, 16'h0});

        // reset asserted mid-packet abandons it; next packet frames cleanly
        v4 = 1; sop = 1; kind = 0; d = l4(8'h50, 8'h51, 8'h52, 8'h53);
        tick();
        chk("rst_b1", {k4, td4}, {4'b0001, l4(STP, 8'h50, 8'h51, 8'h52)});
        rst_n = 0; sop = 0; d = l4(8'h54, 8'h55, 8'h56, 8'h57);
        tick();
        chk("rst_mid", {r4, p4, k4, td4}, 40'h0);
        rst_n = 1; v4 = 0;
        tick();
        chk("rst_release", {r4, k4, td4}, {1'b1, 4'b0000, 32'h0});
        v4 = 1; sop = 1; kind = 1; d = l4(8'h60, 8'h61, 8'h62, 8'h63);
        tick();
        chk("rst_new_sop", {k4, td4}, {4'b0001, l4(SDP, 8'h60, 8'h61, 8'h62)});
        sop = 0; kind = 0; eop = 1; nb = 3'd2; d = l4(8'h64, 8'h65, 8'hEE, 8'hEE);
        tick();
        chk("rst_new_eop", {k4, td4}, {4'b1000, l4(8'h63, 8'h64, 8'h65, ENDK)});
        v4 = 0; eop = 0;
        tick();
        chk("rst_new_idle", {k4, td4}, {4'b0000, 32'h0});

`ifndef PCIE_FRAMER_SKP_EN
        // without SKP support the short-interval instance must stay silent
        begin
            logic saw_k, saw_com, saw_pend;
            saw_k = 0; saw_com = 0; saw_pend = 0;
            for (int i = 0; i < 10000; i++) begin
                tick();
                if (k16 != 4'b0000) saw_k = 1;
                if (p16) saw_pend = 1;
                for (int j = 0; j < 4; j++)
                    if (td16[8*j +: 8] == COM) saw_com = 1;
            end
            chk("noskp_com", {38'd0, saw_com, saw_k}, 40'd0);
            chk("noskp_pending", {39'd0, saw_pend}, 40'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_tx_framer.md
PCIE_TX_FRAMER -- requirements
Module: pcie_tx_framer

Interface
REQ-001 Parameter LANES, default 4, number of byte lanes per cycle; legal values 2 and 4 only.
REQ-002 Parameter SKP_INTERVAL, default 1180, cycles between SKP ordered-set requests; legal range 16..4095.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  the input beat is valid.
REQ-006 in_ready  output  1  the framer accepts the beat this cycle.
REQ-007 in_data  input  8*LANES  packet bytes; lane 0 is bits [7:0] and carries the earliest byte.
REQ-008 in_sop, in_eop  input  1 each  first beat and last beat of a packet.
REQ-009 in_kind  input  1  0 = TLP, 1 = DLLP; sampled on the sop beat.
REQ-010 in_nbytes  input  3  valid bytes (1..LANES) on the eop beat; lanes 0..n-1 hold them.
REQ-011 in_bad  input  1  nullify the packet; sampled on the eop beat.
REQ-012 tx_data  output  8*LANES  symbol per lane.
REQ-013 tx_k  output  LANES  per-lane K-symbol flag.
REQ-014 skp_pending  output  1  a SKP ordered set is owed and not yet started.

Function
REQ-015 tx_data and tx_k SHALL be registered, with one cycle of latency from beat acceptance; the outputs carry a symbol every cycle.
REQ-016 States: IDLE, PKT, TAIL, SKP; in_ready SHALL be 1 in IDLE and PKT and 0 in TAIL and SKP, except that in_ready SHALL be 0 in IDLE while skp_pending is 1.
REQ-017 IDLE with no accepted sop: every lane SHALL output logical idle (data 8'h00, k=0).
REQ-018 A sop beat accepted in IDLE: lane 0 = STP (K27.7) for a TLP or SDP (K28.2) for a DLLP, k=1; lanes 1..LANES-1 = in_data lanes 0..LANES-2; lane LANES-1 of in_data goes to a carry register; state goes to PKT.
REQ-019 A non-eop beat in PKT: lane 0 = carry, lanes 1..LANES-1 = in lanes 0..LANES-2, then carry <= in lane LANES-1.
REQ-020 Eop beat with n<=LANES-2: data occupies lanes 1..n, END (K29.7) or EDB (K30.7 when in_bad) is placed at lane n+1, PAD (K23.7) fills the remaining lanes, and the next state is IDLE or SKP.
REQ-021 Eop beat with n=LANES-1: data fills lanes 1..LANES-1; TAIL then outputs END/EDB on lane 0 and PAD on the others.
REQ-022 Eop beat with n=LANES: carry <= in lane LANES-1; TAIL then outputs carry on lane 0, END/EDB on lane 1, and PAD on the others.
REQ-023 A sop beat in PKT, or an in_sop beat received outside a packet without being accepted, is a protocol error; the framer SHALL ignore in_sop while in PKT; minimum packet length is 6 bytes, so sop and eop never share a beat.
REQ-024 In PKT with in_valid=0, the framer SHALL hold its state and carry and output logical idle on all lanes; the bubble is legal only inside DLLPs for the test mode, and the production link keeps in_valid continuous from sop to eop.
REQ-025 SKP counter: 12-bit, counts every cycle; when it reaches SKP_INTERVAL-1 it SHALL set skp_pending and wrap to 0; a wrap that occurs while skp_pending is already set is absorbed (the pending requests do not stack).
REQ-026 SKP SHALL start only from IDLE or on TAIL/eop exit: 4 cycles of COM (K28.5), SKP (K28.0), SKP, SKP, with the same symbol on all lanes and k=1; skp_pending SHALL clear in the first SKP cycle.
REQ-027 A SKP due in mid-packet SHALL be deferred until the packet ends; it is never inserted inside a packet.

Reset
REQ-028 While rst_n=0 at a clk edge: state <= IDLE, carry <= 0, SKP counter <= 0, skp_pending <= 0, tx_data <= 0, tx_k <= 0, in_ready <= 0 (registered); a reset asserted mid-packet abandons the packet with no END.

Configuration
REQ-029 Macro PCIE_FRAMER_SKP_EN: when defined, REQ-025..027 apply; when undefined, the counter and the SKP state are absent, skp_pending is tied to 0, and the framer never emits COM/SKP.

Structure
REQ-030 The K-code constants (COM, STP, SDP, END, EDB, PAD, SKP) and their 8-bit values, plus a framer_state_e enum, SHALL live in the shared PCIe package.
REQ-031 One sub-module, pcie_skp_timer (counter plus pending flag), SHALL be instantiated under PCIE_FRAMER_SKP_EN.

Verification
REQ-032 LANES=4, 8-byte TLP 01..08 (beat 1 sop, beat 2 eop n=4) -> {STP,01,02,03}, {04,05,06,07}, TAIL {08,END,PAD,PAD}.
REQ-033 LANES=4, 6-byte DLLP, eop n=2 -> {SDP,b0,b1,b2}, {b3,b4,b5,END}, next cycle IDLE zeros.
REQ-034 LANES=2, 7-byte TLP with in_bad on eop (n=1) -> STP b0 | b1 b2 | b3 b4 | b5 b6 | EDB PAD.
REQ-035 SKP_INTERVAL=16 with the counter expiring mid-packet -> skp_pending=1, in_ready=0 after eop, then 4 cycles COM/SKP/SKP/SKP on all lanes, then IDLE.
REQ-036 rst_n=0 asserted during PKT -> the next cycle outputs all zeros, k=0, state IDLE; a new sop after release frames correctly.
REQ-037 Build without PCIE_FRAMER_SKP_EN and run 10000 idle cycles -> no K28.5 ever appears and skp_pending stays 0.
